demux4_stream: RTL and testbench

DEMUX4_STREAM -- requirements
Module: demux4_stream

---
 rtl/demux4_stream_pkg.sv | 20 ++
 rtl/demux_chan_fifo.sv | 75 +++++++
 rtl/demux4_stream.sv | 51 +++++
 tb/tb_demux4_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_stream_pkg.sv
// Shared constants and types for the 4-way stream demultiplexer.
//   NUM_CH     : number of output channels
//   SEL_W      : width of the channel select
//   CHAN_DEPTH : entries per channel buffer
//   CNT_W      : width of a per-channel entry count
//   chan_state_e : per-channel fill state; encoding equals the entry count
package demux4_stream_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned CHAN_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } chan_state_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry FIFO for one demux channel.
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_push      : write i_data this edge (caller guarantees not full)
//   i_data      : beat payload
//   i_out_ready : consumer takes the head beat when o_valid is high
//   o_valid     : head beat present
//   o_full      : registered full flag
//   o_data      : head payload, stable while o_valid and not popped
//   o_count     : entry count 0..2
module demux_chan_fifo
  import demux4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = CHAN_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_valid,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;

  assign w_pop = (r_state != EMPTY) && i_out_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // 1-bit pointers wrap 1 -> 0 naturally
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Storage carries no reset; occupancy state alone decides validity.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY:   if (i_push) w_state_nxt = ONE;
      ONE: begin
        if (i_push && !w_pop)      w_state_nxt = FULL;
        else if (w_pop && !i_push) w_state_nxt = EMPTY;
      end
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    o_valid = (r_state != EMPTY);
    o_full  = (r_state == FULL);
    o_data  = r_mem[r_rd_ptr];
    o_count = r_state;
  end

endmodule

// File: rtl/demux4_stream.sv
// Routes a single valid/ready input stream to one of four buffered output
// channels chosen by in_sel. Each channel has its own 2-entry FIFO, so a full
// channel only stalls beats addressed to it.
//   clk, reset : clock and asynchronous active-high reset
//   in_valid / in_ready / in_sel / in_data : upstream beat and destination
//   out_valid / out_ready / out_data       : per-channel downstream handshakes
//   occupancy  : 2-bit entry count per channel, channel k at [2k+1:2k]
module demux4_stream
  import demux4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH*CNT_W-1:0] occupancy
);

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push;

  // Ready depends only on registered full flags, never on out_ready.
  assign in_ready = ~w_full[in_sel];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_push[g] = in_valid && in_ready && (in_sel == SEL_W'(g));

    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_push      (w_push[g]),
      .i_data      (in_data),
      .i_out_ready (out_ready[g]),
      .o_valid     (out_valid[g]),
      .o_full      (w_full[g]),
      .o_data      (out_data[g*WIDTH +: WIDTH]),
      .o_count     (occupancy[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux4_stream.sv
module tb_demux4_stream;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [7:0]     occupancy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: one FIFO queue per channel, capacity two.
  logic [W-1:0] q0[$], q1[$], q2[$], q3[$];

  demux4_stream #(.WIDTH(W), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [1:0]   sel;
    logic [W-1:0] d;
    logic [3:0]   ordy;
    logic         exp_ir;
    logic [3:0]   exp_ov;
    logic [7:0]   exp_occ;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [W-1:0] qhead(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic qpush(input int k, input logic [W-1:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  task automatic check_model();
    logic [7:0] occ;
    logic [3:0] ov;
    occ = '0;
    ov  = '0;
    for (int k = 0; k < 4; k++) begin
      occ[k*2 +: 2] = 2'(qsize(k));
      ov[k]         = (qsize(k) != 0);
    end
    chk("model_in_ready", {31'd0, in_ready}, {31'd0, qsize(int'(in_sel)) < 2});
    chk("model_out_valid", {28'd0, out_valid}, {28'd0, ov});
    chk("model_occupancy", {24'd0, occupancy}, {24'd0, occ});
    for (int k = 0; k < 4; k++)
      if (qsize(k) != 0)
        chk($sformatf("model_data_ch%0d", k), {28'd0, out_data[k*W +: W]}, {28'd0, qhead(k)});
  endtask

  // Inputs are set at the negedge before calling; advances one clock.
  task automatic cycle();
    bit         acc;
    bit   [3:0] pops;
    int         s;
    s    = int'(in_sel);
    acc  = !reset && in_valid && (qsize(s) < 2);
    pops = '0;
    for (int k = 0; k < 4; k++) pops[k] = !reset && (qsize(k) != 0) && out_ready[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (pops[k]) qpop(k);
    if (acc) qpush(s, in_data);
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 4'h1, 4'hF, 1'b1, 4'b0001, 8'h01};
    vecs[1]  = '{1'b1, 2'd1, 4'h0, 4'hF, 1'b1, 4'b0010, 8'h04};
    vecs[2]  = '{1'b1, 2'd2, 4'h1, 4'hF, 1'b1, 4'b0100, 8'h10};
    vecs[3]  = '{1'b1, 2'd3, 4'h1, 4'hF, 1'b1, 4'b1000, 8'h40};
    vecs[4]  = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 8'h00};
    vecs[5]  = '{1'b1, 2'd2, 4'h5, 4'h0, 1'b1, 4'b0100, 8'h10};
    vecs[6]  = '{1'b1, 2'd2, 4'h6, 4'h0, 1'b1, 4'b0100, 8'h20};
    vecs[7]  = '{1'b1, 2'd2, 4'h7, 4'h0, 1'b0, 4'b0100, 8'h20};
    vecs[8]  = '{1'b1, 2'd1, 4'h9, 4'h0, 1'b1, 4'b0110, 8'h24};
    vecs[9]  = '{1'b1, 2'd1, 4'h3, 4'h2, 1'b1, 4'b0110, 8'h24};
    vecs[10] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0100, 8'h10};
    vecs[11] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 8'h00};
    vecs[12] = '{1'b1, 2'd3, 4'hA, 4'h0, 1'b1, 4'b1000, 8'h40};
    vecs[13] = '{1'b1, 2'd3, 4'hB, 4'h0, 1'b1, 4'b1000, 8'h80};
    vecs[14] = '{1'b1, 2'd3, 4'hC, 4'h8, 1'b0, 4'b1000, 8'h40};
    vecs[15] = '{1'b1, 2'd3, 4'hC, 4'h0, 1'b1, 4'b1000, 8'h80};
    vecs[16] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b1000, 8'h40};
    vecs[17] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 8'h00};

    reset = 1'b1;
    drive(1'b0, 2'd0, '0, 4'h0);
    model_clear();
    #1;
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_occupancy", {24'd0, occupancy}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle_out_valid", {28'd0, out_valid}, 32'd0);
      chk("idle_occupancy", {24'd0, occupancy}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    end

    // Directed table
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
      #1;
      cycle();
      chk($sformatf("vec%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_occupancy", i), {24'd0, occupancy}, {24'd0, vecs[i].exp_occ});
    end

    // Channels 0 and 2 full, then reset mid-cycle with a beat offered
    drive(1'b1, 2'd0, 4'h1, 4'h0); cycle();
    drive(1'b1, 2'd0, 4'h2, 4'h0); cycle();
    drive(1'b1, 2'd2, 4'h3, 4'h0); cycle();
    drive(1'b1, 2'd2, 4'h4, 4'h0); cycle();
    chk("prerst_occupancy", {24'd0, occupancy}, 32'h22);
    drive(1'b1, 2'd1, 4'hE, 4'hF);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_async_occupancy", {24'd0, occupancy}, 32'd0);
    chk("rst_async_in_ready", {31'd0, in_ready}, 32'd1);
    model_clear();
    @(negedge clk);
    cycle();
    chk("rst_hold_out_valid", {28'd0, out_valid}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 2'd0, 4'h7, 4'h0); cycle();
    drive(1'b1, 2'd2, 4'h8, 4'h0); cycle();
    drive(1'b1, 2'd0, 4'h9, 4'h0); cycle();
    chk("postrst_ch0_head", {28'd0, out_data[0 +: W]}, 32'h7);
    chk("postrst_ch2_head", {28'd0, out_data[2*W +: W]}, 32'h8);
    drive(1'b0, 2'd0, 4'h0, 4'h1); cycle();
    chk("postrst_ch0_second", {28'd0, out_data[0 +: W]}, 32'h9);
    drive(1'b0, 2'd0, 4'h0, 4'hF); cycle();
    cycle();

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom), 2'($urandom_range(0, 3)), W'($urandom), 4'($urandom));
      if ((i % 150) == 149) begin
        #2 reset = 1'b1;
        model_clear();
        #1;
        chk("rand_rst_out_valid", {28'd0, out_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
